// File: rtl/projectile_pool.sv
// Purpose: pool of N_SLOTS upward-moving projectiles with fire-edge launch, cooldown, kill and per-pixel hit query.
// Latency: launch, movement, kill and derived outputs one cycle after the event; pixel hit one cycle after the pixel.
// Backpressure: none; tick, fire and kill are consumed in the cycle presented, rejected fire edges are dropped.
module projectile_pool #(
  parameter int N_SLOTS  = 8,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int STEP     = 5,
  parameter int PROJ_W   = 4,
  parameter int PROJ_H   = 8,
  parameter int X_OFFSET = 8,
  parameter int COOLDOWN = 16,
  localparam int IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  localparam int CNT_W   = $clog2(N_SLOTS + 1)
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               tick,
  input  logic               fire,
  input  logic [X_W-1:0]     origin_x,
  input  logic [Y_W-1:0]     origin_y,
  input  logic               kill_valid,
  input  logic [IDX_W-1:0]   kill_idx,
  input  logic [X_W-1:0]     pixel_x,
  input  logic [Y_W-1:0]     pixel_y,
  output logic               pixel_hit,
  output logic [IDX_W-1:0]   pixel_hit_idx,
  output logic [N_SLOTS-1:0] active_mask,
  output logic [CNT_W-1:0]   active_count,
  output logic               pool_full,
  output logic               fire_accepted
);

  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [N_SLOTS-1:0] active_q, active_d;
  logic [X_W-1:0]     x_q [N_SLOTS];
  logic [X_W-1:0]     x_d [N_SLOTS];
  logic [Y_W-1:0]     y_q [N_SLOTS];
  logic [Y_W-1:0]     y_d [N_SLOTS];
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               fire_q;
  logic               fire_acc_q;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q;

  logic               fire_edge;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               launch;

  assign fire_edge = fire & ~fire_q;
  assign launch    = fire_edge && (cd_q == '0) && free_found;

  // Lowest-index free slot from the state at the start of the cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int s = N_SLOTS - 1; s >= 0; s--) begin
      if (!active_q[s]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(s);
      end
    end
  end

  // Slot next state: move/retire on tick, kill overrides, then launch into the free slot.
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    for (int s = 0; s < N_SLOTS; s++) begin
      if (active_q[s]) begin
        if (tick) begin
          if ({1'b0, y_q[s]} >= (Y_W+1)'(STEP)) y_d[s] = y_q[s] - Y_W'(STEP);
          else                                  active_d[s] = 1'b0;
        end
        if (kill_valid && (kill_idx == IDX_W'(s))) begin
          active_d[s] = 1'b0;
          y_d[s]      = y_q[s];
        end
      end else if (launch && (free_idx == IDX_W'(s))) begin
        active_d[s] = 1'b1;
        x_d[s]      = origin_x + X_W'(X_OFFSET);
        y_d[s]      = origin_y;
      end
    end
  end

  // Cooldown: a launch reloads it, otherwise it counts down on ticks until zero.
  always_comb begin
    cd_d = cd_q;
    if (launch)                    cd_d = CD_W'(COOLDOWN);
    else if (tick && cd_q != '0)   cd_d = cd_q - CD_W'(1);
  end

  // Pixel overlap against live slots; upper bounds carry one extra bit so edge slots don't wrap.
  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = '0;
    for (int s = N_SLOTS - 1; s >= 0; s--) begin
      if (active_q[s] &&
          (pixel_x >= x_q[s]) && ({1'b0, pixel_x} < ({1'b0, x_q[s]} + (X_W+1)'(PROJ_W))) &&
          (pixel_y >= y_q[s]) && ({1'b0, pixel_y} < ({1'b0, y_q[s]} + (Y_W+1)'(PROJ_H)))) begin
        hit_d     = 1'b1;
        hit_idx_d = IDX_W'(s);
      end
    end
  end

  // Population count of the post-update live mask.
  always_comb begin
    count_d = '0;
    for (int s = 0; s < N_SLOTS; s++) count_d = count_d + CNT_W'(active_d[s]);
  end

  // State and registered outputs.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      active_q   <= '0;
      cd_q       <= '0;
      fire_q     <= 1'b0;
      fire_acc_q <= 1'b0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      for (int s = 0; s < N_SLOTS; s++) begin
        x_q[s] <= '0;
        y_q[s] <= '0;
      end
    end else begin
      active_q   <= active_d;
      cd_q       <= cd_d;
      fire_q     <= fire;
      fire_acc_q <= launch;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      count_q    <= count_d;
      full_q     <= &active_d;
      for (int s = 0; s < N_SLOTS; s++) begin
        x_q[s] <= x_d[s];
        y_q[s] <= y_d[s];
      end
    end
  end

  assign pixel_hit     = hit_q;
  assign pixel_hit_idx = hit_idx_q;
  assign active_mask   = active_q;
  assign active_count  = count_q;
  assign pool_full     = full_q;
  assign fire_accepted = fire_acc_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench: instance a uses default parameters (cooldown 16), instance b has cooldown 0.
// Both share all inputs; inputs change 1 time unit after the rising edge and outputs are sampled there.
module tb_projectile_pool;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, fire = 1'b0, kill_valid = 1'b0;
  logic [9:0] origin_x = '0, pixel_x = '0;
  logic [8:0] origin_y = '0, pixel_y = '0;
  logic [2:0] kill_idx = '0;

  logic       a_hit, b_hit, a_full, b_full, a_acc, b_acc;
  logic [2:0] a_idx, b_idx;
  logic [7:0] a_mask, b_mask;
  logic [3:0] a_cnt, b_cnt;

  int n_total = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  projectile_pool a (
    .iVGA_CLK(clk), .iRST_n(rst_n), .tick(tick), .fire(fire),
    .origin_x(origin_x), .origin_y(origin_y), .kill_valid(kill_valid), .kill_idx(kill_idx),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_hit(a_hit), .pixel_hit_idx(a_idx),
    .active_mask(a_mask), .active_count(a_cnt), .pool_full(a_full), .fire_accepted(a_acc)
  );

  projectile_pool #(.COOLDOWN(0)) b (
    .iVGA_CLK(clk), .iRST_n(rst_n), .tick(tick), .fire(fire),
    .origin_x(origin_x), .origin_y(origin_y), .kill_valid(kill_valid), .kill_idx(kill_idx),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_hit(b_hit), .pixel_hit_idx(b_idx),
    .active_mask(b_mask), .active_count(b_cnt), .pool_full(b_full), .fire_accepted(b_acc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic edge_fire(input logic [9:0] ox, input logic [8:0] oy, output logic acc_a, output logic acc_b);
    origin_x = ox;
    origin_y = oy;
    fire = 1'b1;
    cyc();
    acc_a = a_acc;
    acc_b = b_acc;
    fire = 1'b0;
    cyc();
  endtask

  task automatic query(input logic [9:0] px, input logic [8:0] py);
    pixel_x = px;
    pixel_y = py;
    cyc();
  endtask

  initial begin
    logic aa, ba;
    int   a_n, b_n, a_last;

    // Reset and idle
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (100) cyc();
    chk("idle_hit", a_hit, 0);
    chk("idle_idx", a_idx, 0);
    chk("idle_mask", a_mask, 0);
    chk("idle_cnt", a_cnt, 0);
    chk("idle_full", a_full, 0);
    chk("idle_acc", a_acc, 0);

    // Held fire launches once
    origin_x = 10'd320;
    origin_y = 9'd450;
    fire = 1'b1;
    a_n = 0;
    b_n = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (a_acc) a_n++;
      if (b_acc) b_n++;
    end
    fire = 1'b0;
    cyc();
    chk("held_pulses_a", a_n, 1);
    chk("held_pulses_b", b_n, 1);
    chk("held_mask", a_mask, 8'h01);
    chk("held_cnt", a_cnt, 1);
    query(10'd328, 9'd450); chk("launch_hit_tl", a_hit, 1); chk("launch_idx", a_idx, 0);
    query(10'd327, 9'd450); chk("launch_left_miss", a_hit, 0);
    query(10'd331, 9'd457); chk("launch_hit_br", a_hit, 1);
    query(10'd332, 9'd450); chk("launch_right_excl", a_hit, 0);
    query(10'd328, 9'd458); chk("launch_bottom_excl", a_hit, 0);

    // Edges every two ticks: a accepts only after 16 ticks, b fills up and drops the 9th edge
    a_n = 0;
    b_n = 0;
    a_last = 0;
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      do_tick();
      edge_fire(10'd320, 9'd450, aa, ba);
      if (aa) begin a_n++; a_last = i; end
      if (ba) b_n++;
      if (i == 8) chk("ninth_edge_dropped_b", ba, 0);
    end
    chk("cd_accepts_a", a_n, 1);
    chk("cd_accept_at_16", a_last, 8);
    chk("cd_mask_a", a_mask, 8'h03);
    chk("cd_cnt_a", a_cnt, 2);
    chk("full_accepts_b", b_n, 7);
    chk("full_b", b_full, 1);
    chk("full_cnt_b", b_cnt, 8);
    query(10'd328, 9'd370); chk("moved_hit_slot0", a_hit, 1);
    query(10'd328, 9'd369); chk("moved_above_miss", a_hit, 0);
    query(10'd330, 9'd452); chk("slot1_idx", a_idx, 1);

    // Asynchronous reset mid-flight
    rst_n = 1'b0;
    #1;
    chk("arst_mask_a", a_mask, 0);
    chk("arst_full_b", b_full, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Retirement at the top edge without wrap
    edge_fire(10'd100, 9'd7, aa, ba);
    chk("y7_launch", aa, 1);
    do_tick();
    query(10'd108, 9'd2); chk("y2_hit", a_hit, 1);
    query(10'd108, 9'd1); chk("y2_above_miss", a_hit, 0);
    do_tick();
    chk("retired_mask", a_mask, 0);
    chk("retired_cnt", a_cnt, 0);
    query(10'd108, 9'd509); chk("no_wrap_509", a_hit, 0);

    // Same-cycle tick, kill of slot 0 and fire edge
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    edge_fire(10'd200, 9'd300, aa, ba);
    repeat (16) do_tick();
    tick = 1'b1; kill_valid = 1'b1; kill_idx = 3'd0;
    origin_x = 10'd50; origin_y = 9'd200; fire = 1'b1;
    cyc();
    chk("combo_acc", a_acc, 1);
    chk("combo_mask", a_mask, 8'h02);
    chk("combo_cnt", a_cnt, 1);
    tick = 1'b0; kill_valid = 1'b0; fire = 1'b0;
    cyc();
    query(10'd58, 9'd200); chk("combo_new_hit", a_hit, 1); chk("combo_new_idx", a_idx, 1);
    query(10'd58, 9'd199); chk("combo_new_unmoved", a_hit, 0);
    query(10'd208, 9'd220); chk("combo_killed", a_hit, 0);

    // Fill b: slot0 dummy, 2 at (100,100), 3/4 dummy, 5 at (100,100), 6 at x=636, 7 at x=1022
    edge_fire(10'd0,    9'd0,   aa, ba);
    edge_fire(10'd92,   9'd100, aa, ba);
    edge_fire(10'd0,    9'd0,   aa, ba);
    edge_fire(10'd0,    9'd0,   aa, ba);
    edge_fire(10'd92,   9'd100, aa, ba);
    edge_fire(10'd628,  9'd100, aa, ba);
    edge_fire(10'd1014, 9'd100, aa, ba);
    chk("fill_full_b", b_full, 1);
    chk("fill_cnt_b", b_cnt, 8);
    chk("cd_blocks_a", a_cnt, 1);
    query(10'd101, 9'd103); chk("overlap_hit", b_hit, 1); chk("overlap_lowest", b_idx, 2);
    query(10'd104, 9'd100); chk("overlap_right_excl", b_hit, 0);
    query(10'd103, 9'd108); chk("overlap_bottom_excl", b_hit, 0);
    query(10'd639, 9'd100); chk("x636_hit", b_hit, 1); chk("x636_idx", b_idx, 6);
    query(10'd640, 9'd100); chk("x636_right_excl", b_hit, 0);
    query(10'd1023, 9'd107); chk("x1022_hit", b_hit, 1); chk("x1022_idx", b_idx, 7);

    // Kill slot 2 in b; a has no slot 2 live
    kill_valid = 1'b1; kill_idx = 3'd2;
    cyc();
    kill_valid = 1'b0;
    chk("kill_cnt_b", b_cnt, 7);
    chk("kill_full_b", b_full, 0);
    chk("kill_inactive_a", a_cnt, 1);
    query(10'd101, 9'd103); chk("kill_next_idx", b_idx, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
